// File: rtl/epp_host_port.sv
// epp_host_port: EPP parallel-port bridge to an internal 8-bit register bus.
// Each host strobe becomes one address update or one register read/write.
module epp_host_port #(
    parameter bit AUTO_INC = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usb_write,
    input  logic       usb_astb,
    input  logic       usb_dstb,
    output logic       usb_wait,
    inout  wire  [7:0] usb_db,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        ACK
    } state_t;

    state_t state, state_nx;

    logic [1:0] astb_sr;
    logic [1:0] dstb_sr;
    logic [1:0] write_sr;
    logic [7:0] db_meta;
    logic [7:0] s_db;
    logic       s_astb;
    logic       s_dstb;
    logic       s_write;

    logic       addr_ld;
    logic       addr_rd;
    logic       wr_go;
    logic       rd_go;
    logic       rd_cap;
    logic       rd_done;
    logic       leave;

    logic [7:0] out_latch;
    logic       db_oe;
    logic       data_xfer;

    // Strobes idle high, so every synchroniser resets to all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            astb_sr  <= 2'b11;
            dstb_sr  <= 2'b11;
            write_sr <= 2'b11;
            db_meta  <= 8'hFF;
            s_db     <= 8'hFF;
        end else begin
            astb_sr  <= {astb_sr[0], usb_astb};
            dstb_sr  <= {dstb_sr[0], usb_dstb};
            write_sr <= {write_sr[0], usb_write};
            db_meta  <= usb_db;
            s_db     <= db_meta;
        end
    end

    assign s_astb  = astb_sr[1];
    assign s_dstb  = dstb_sr[1];
    assign s_write = write_sr[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Address strobe wins when both strobes are seen low together.
    always_comb begin
        state_nx = state;
        addr_ld  = 1'b0;
        addr_rd  = 1'b0;
        wr_go    = 1'b0;
        rd_go    = 1'b0;
        rd_cap   = 1'b0;
        rd_done  = 1'b0;
        leave    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!s_astb) begin
                    state_nx = ACK;
                    if (!s_write) addr_ld = 1'b1;
                    else          addr_rd = 1'b1;
                end else if (!s_dstb) begin
                    if (!s_write) begin
                        wr_go    = 1'b1;
                        state_nx = ACK;
                    end else begin
                        rd_go    = 1'b1;
                        state_nx = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                rd_cap   = 1'b1;
                state_nx = RD_CAP;
            end
            RD_CAP: begin
                rd_done  = 1'b1;
                state_nx = ACK;
            end
            ACK: begin
                if (s_astb && s_dstb) begin
                    leave    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign reg_re = (state == RD_REQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            reg_we    <= 1'b0;
            out_latch <= 8'h00;
            db_oe     <= 1'b0;
            usb_wait  <= 1'b0;
            data_xfer <= 1'b0;
        end else begin
            reg_we   <= wr_go;
            usb_wait <= (state_nx == ACK);
            if (wr_go)
                reg_wdata <= s_db;
            if (addr_ld || addr_rd)
                data_xfer <= 1'b0;
            else if (wr_go || rd_go)
                data_xfer <= 1'b1;
            if (addr_ld)
                reg_addr <= s_db;
            else if (leave && AUTO_INC && data_xfer)
                reg_addr <= reg_addr + 8'd1;
            if (addr_rd)
                out_latch <= reg_addr;
            else if (rd_cap)
                out_latch <= reg_rdata;
            if (addr_rd || rd_done)
                db_oe <= 1'b1;
            else if (leave)
                db_oe <= 1'b0;
        end
    end

    assign usb_db = db_oe ? out_latch : 8'hzz;

endmodule

// File: tb/tb_epp_host_port.sv
// tb_epp_host_port: drives EPP host transfers into a plain and an
// auto-increment bridge and checks both against a register-file model.
module tb_epp_host_port;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic usb_write = 1'b1;
    logic usb_astb = 1'b1;
    logic usb_dstb = 1'b1;
    logic host_oe = 1'b0;
    logic [7:0] host_db = 8'h00;

    tri1 [7:0] db0;
    tri1 [7:0] db1;
    assign db0 = host_oe ? host_db : 8'hzz;
    assign db1 = host_oe ? host_db : 8'hzz;

    logic       wait0, wait1;
    logic [7:0] ra0, ra1, wd0, wd1;
    logic       we0, we1, re0, re1;
    logic [7:0] rdat0, rdat1;

    logic [7:0] cm0 [256];
    logic [7:0] cm1 [256];
    assign rdat0 = cm0[ra0];
    assign rdat1 = cm1[ra1];

    epp_host_port #(.AUTO_INC(1'b0)) u_plain (
        .clk(clk), .rst(rst), .usb_write(usb_write),
        .usb_astb(usb_astb), .usb_dstb(usb_dstb),
        .usb_wait(wait0), .usb_db(db0),
        .reg_addr(ra0), .reg_wdata(wd0),
        .reg_we(we0), .reg_re(re0), .reg_rdata(rdat0)
    );

    epp_host_port #(.AUTO_INC(1'b1)) u_inc (
        .clk(clk), .rst(rst), .usb_write(usb_write),
        .usb_astb(usb_astb), .usb_dstb(usb_dstb),
        .usb_wait(wait1), .usb_db(db1),
        .reg_addr(ra1), .reg_wdata(wd1),
        .reg_we(we1), .reg_re(re1), .reg_rdata(rdat1)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    int we_cnt0 = 0, we_cnt1 = 0, re_cnt0 = 0, re_cnt1 = 0;
    int both_hi = 0;
    logic [7:0] we_addr0, we_addr1, we_data0, we_data1;

    // Consumer side: register file written by reg_we pulses.
    always @(negedge clk) begin
        if (we0) begin
            we_cnt0++; we_addr0 = ra0; we_data0 = wd0; cm0[ra0] = wd0;
        end
        if (we1) begin
            we_cnt1++; we_addr1 = ra1; we_data1 = wd1; cm1[ra1] = wd1;
        end
        if (re0) re_cnt0++;
        if (re1) re_cnt1++;
        if ((we0 && re0) || (we1 && re1)) both_hi++;
    end

    // Reference model: host-visible address and register contents.
    logic [7:0] m_addr0 = 8'h00, m_addr1 = 8'h00;
    logic [7:0] exp0 [256];
    logic [7:0] exp1 [256];
    logic [7:0] last_rd0, last_rd1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic xfer(input bit is_addr, input bit hw,
                        input logic [7:0] d,
                        output logic [7:0] r0, output logic [7:0] r1,
                        output int rise, output int fall);
        @(negedge clk);
        usb_write = ~hw;
        host_db = d;
        host_oe = hw;
        if (is_addr) usb_astb = 1'b0;
        else         usb_dstb = 1'b0;
        rise = 0;
        while (!(wait0 && wait1) && rise < 20) begin
            @(negedge clk);
            rise++;
        end
        r0 = db0;
        r1 = db1;
        usb_astb = 1'b1;
        usb_dstb = 1'b1;
        fall = 0;
        while ((wait0 || wait1) && fall < 20) begin
            @(negedge clk);
            fall++;
        end
        host_oe = 1'b0;
    endtask

    // kind: 0 addr write, 1 addr read, 2 data write, 3 data read
    task automatic do_op(input int kind, input logic [7:0] d);
        int w0, w1, q0, q1, rise, fall;
        logic [7:0] r0, r1;
        w0 = we_cnt0; w1 = we_cnt1; q0 = re_cnt0; q1 = re_cnt1;
        xfer(kind < 2, kind == 0 || kind == 2, d, r0, r1, rise, fall);
        last_rd0 = r0;
        last_rd1 = r1;
        chk("rise_cycles", rise, (kind == 3) ? 5 : 3);
        chk("fall_cycles", fall, 3);
        chk("we_count0", we_cnt0 - w0, (kind == 2) ? 1 : 0);
        chk("re_count0", re_cnt0 - q0, (kind == 3) ? 1 : 0);
        chk("we_count1", we_cnt1 - w1, (kind == 2) ? 1 : 0);
        chk("re_count1", re_cnt1 - q1, (kind == 3) ? 1 : 0);
        case (kind)
            0: begin
                m_addr0 = d;
                m_addr1 = d;
            end
            1: begin
                chk("addr_read0", r0, m_addr0);
                chk("addr_read1", r1, m_addr1);
            end
            2: begin
                exp0[m_addr0] = d;
                exp1[m_addr1] = d;
                chk("we_addr0", we_addr0, m_addr0);
                chk("we_data0", we_data0, d);
                chk("we_addr1", we_addr1, m_addr1);
                chk("we_data1", we_data1, d);
                m_addr1 = m_addr1 + 8'd1;
            end
            default: begin
                chk("data_read0", r0, exp0[m_addr0]);
                chk("data_read1", r1, exp1[m_addr1]);
                m_addr1 = m_addr1 + 8'd1;
            end
        endcase
        if (kind == 1 || kind == 3) begin
            chk("db_release0", db0, 8'hFF);
            chk("db_release1", db1, 8'hFF);
        end
        chk("reg_addr0", ra0, m_addr0);
        chk("reg_addr1", ra1, m_addr1);
    endtask

    logic [7:0] inc_seen [3];

    initial begin
        int w0, t;
        for (int i = 0; i < 256; i++) begin
            cm0[i] = 8'(i * 7 + 3);
            cm1[i] = 8'(i * 7 + 3);
            exp0[i] = 8'(3 + 7 * i);
            exp1[i] = 8'(3 + 7 * i);
        end

        repeat (3) @(negedge clk);
        chk("rst_wait", wait0, 1'b0);
        chk("rst_addr", ra0, 8'h00);
        chk("rst_wdata", wd0, 8'h00);
        chk("rst_we", we0, 1'b0);
        chk("rst_re", re0, 1'b0);
        chk("rst_db", db0, 8'hFF);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_op(0, 8'h05);
        chk("addr_05", ra0, 8'h05);
        do_op(2, 8'hA5);
        chk("wr_addr_05", we_addr0, 8'h05);
        chk("wr_data_A5", we_data0, 8'hA5);
        do_op(0, 8'h05);
        do_op(2, 8'h3C);
        do_op(3, 8'h00);
        chk("rd_3C", last_rd0, 8'h3C);
        do_op(1, 8'h00);

        do_op(0, 8'hFE);
        for (int k = 0; k < 3; k++) begin
            do_op(2, 8'(8'h40 + k));
            inc_seen[k] = we_addr1;
        end
        chk("inc_FE", inc_seen[0], 8'hFE);
        chk("inc_FF", inc_seen[1], 8'hFF);
        chk("inc_00", inc_seen[2], 8'h00);

        // Both strobes low together: address cycle only.
        w0 = we_cnt0;
        @(negedge clk);
        usb_write = 1'b0; host_db = 8'h11; host_oe = 1'b1;
        usb_astb = 1'b0; usb_dstb = 1'b0;
        t = 0;
        while (!wait0 && t < 20) begin @(negedge clk); t++; end
        chk("both_wait", wait0, 1'b1);
        usb_astb = 1'b1; usb_dstb = 1'b1;
        t = 0;
        while ((wait0 || wait1) && t < 20) begin @(negedge clk); t++; end
        host_oe = 1'b0;
        chk("both_addr0", ra0, 8'h11);
        chk("both_addr1", ra1, 8'h11);
        chk("both_no_we", we_cnt0 - w0, 0);
        m_addr0 = 8'h11;
        m_addr1 = 8'h11;

        for (int n = 0; n < 40; n++)
            do_op($urandom_range(0, 3), 8'($urandom));

        chk("we_re_never_both", both_hi, 0);

        // Reset while a data read sits in ACK.
        @(negedge clk);
        usb_write = 1'b1; usb_dstb = 1'b0;
        t = 0;
        while (!wait0 && t < 20) begin @(negedge clk); t++; end
        chk("pre_rst_wait", wait0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_wait", wait0, 1'b0);
        chk("mid_rst_db", db0, 8'hFF);
        chk("mid_rst_addr", ra0, 8'h00);
        chk("mid_rst_wait1", wait1, 1'b0);
        chk("mid_rst_db1", db1, 8'hFF);
        usb_dstb = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        m_addr0 = 8'h00;
        m_addr1 = 8'h00;
        do_op(1, 8'h00);
        do_op(2, 8'h77);
        do_op(0, 8'h00);
        do_op(3, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
